// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 key event path: event field layout and key count.
// The optional auto-repeat feature is enabled with `TM1638_KEY_REPEAT_EN.
package tm1638_pkg;
    localparam int N_KEYS    = 8;
    localparam int IDX_W     = 3;
    localparam int EVENT_W   = 5;
    localparam int EV_RPT    = 4;
    localparam int EV_PRESS  = 3;
    localparam int EV_IDX_HI = 2;
    localparam int EV_IDX_LO = 0;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Lowest set bit wins; returns 0 for an empty vector.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_KEYS-1:0] v);
        lowest_set = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction
endpackage

// File: rtl/tm1638_key_debounce.sv
// Single-key debouncer: the stable level flips only after DEBOUNCE_CYCLES consecutive differing samples.
// rise/fall pulse in the cycle whose clock edge updates stable.
module tm1638_key_debounce
    import tm1638_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 25000
) (
    input  logic clk_5MHz,
    input  logic n_rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             done;

    assign done = (raw != stable) && (cnt == CNT_LAST);
    assign rise = done && raw;
    assign fall = done && !raw;

    // Any sample matching stable restarts the run, so glitches earn no partial credit.
    always_ff @(posedge clk_5MHz) begin
        if (!n_rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tm1638_key_events.sv
// Debounces the TM1638 key vector and queues press/release events into a small valid/ready FIFO.
// Defining `TM1638_KEY_REPEAT_EN adds a hold-to-repeat FSM that emits {1,1,idx} events.
module tm1638_key_events
    import tm1638_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 2500000,
    parameter int REPEAT_RATE     = 500000
) (
    input  logic               clk_5MHz,
    input  logic               n_rst,
    input  logic [N_KEYS-1:0]  keys_raw,
    output logic [N_KEYS-1:0]  keys_stable,
    output logic               event_valid,
    output logic [EVENT_W-1:0] event_data,
    input  logic               event_ready,
    output logic               event_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [N_KEYS-1:0]  keys_q, rise, fall;
    logic [N_KEYS-1:0]  pend_press, pend_rel, clr_press, clr_rel, sel_mask;
    logic               pend_rpt, sel_valid, sel_press, sel_rpt;
    logic [IDX_W-1:0]   sel_idx, rpt_idx;
    logic [EVENT_W-1:0] sel_event;
    logic [EVENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               push, pop, full, do_write;

    always_ff @(posedge clk_5MHz) begin
        if (!n_rst) keys_q <= '0;
        else        keys_q <= keys_raw;
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        tm1638_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk_5MHz (clk_5MHz),
            .n_rst    (n_rst),
            .raw      (keys_q[gi]),
            .stable   (keys_stable[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi])
        );
    end

    // Presses outrank releases, releases outrank repeats; lowest index first within a class.
    always_comb begin
        sel_valid = 1'b0;
        sel_press = 1'b0;
        sel_rpt   = 1'b0;
        sel_idx   = '0;
        if (|pend_press) begin
            sel_valid = 1'b1;
            sel_press = 1'b1;
            sel_idx   = lowest_set(pend_press);
        end else if (|pend_rel) begin
            sel_valid = 1'b1;
            sel_idx   = lowest_set(pend_rel);
        end else if (pend_rpt) begin
            sel_valid = 1'b1;
            sel_press = 1'b1;
            sel_rpt   = 1'b1;
            sel_idx   = rpt_idx;
        end
    end

    assign sel_mask  = {{(N_KEYS-1){1'b0}}, 1'b1} << sel_idx;
    assign clr_press = (sel_valid && sel_press && !sel_rpt) ? sel_mask : '0;
    assign clr_rel   = (sel_valid && !sel_press) ? sel_mask : '0;
    assign sel_event = {sel_rpt, sel_press, sel_idx};

    always_ff @(posedge clk_5MHz) begin
        if (!n_rst) begin
            pend_press <= '0;
            pend_rel   <= '0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | rise;
            pend_rel   <= (pend_rel & ~clr_rel) | fall;
        end
    end

    // Valid/ready: an entry transfers on each clock edge where event_valid && event_ready;
    // event_data is the head entry and holds steady until it transfers.
    assign push        = sel_valid;
    assign event_valid = (count != '0);
    assign pop         = event_valid && event_ready;
    assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign do_write    = push && (!full || pop);
    assign event_data  = event_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_5MHz) begin
        if (do_write) mem[wr_ptr] <= sel_event;
    end

    always_ff @(posedge clk_5MHz) begin
        if (!n_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            event_overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) event_overflow <= 1'b1;
            else if (pop)             event_overflow <= 1'b0;
        end
    end

`ifdef TM1638_KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = $clog2(RPT_MAX) + 1;

    rpt_state_t        state, state_next;
    logic [RC_W-1:0]   rcnt, rcnt_next;
    logic [IDX_W-1:0]  rpt_idx_next;
    logic [N_KEYS-1:0] stable_next;
    logic              changed, rpt_req;

    assign stable_next = keys_stable ^ (rise | fall);
    assign changed     = |(rise | fall);

    always_ff @(posedge clk_5MHz) begin
        if (!n_rst) begin
            state    <= RPT_IDLE;
            rcnt     <= '0;
            rpt_idx  <= '0;
            pend_rpt <= 1'b0;
        end else begin
            state    <= state_next;
            rcnt     <= rcnt_next;
            rpt_idx  <= rpt_idx_next;
            pend_rpt <= (pend_rpt & ~(sel_valid & sel_rpt)) | (rpt_req & ~pend_rpt);
        end
    end

    // A stable-vector change restarts the hold timer directly, so the first repeat lands
    // REPEAT_DELAY cycles after the press itself.
    always_comb begin
        state_next   = state;
        rcnt_next    = rcnt + 1'b1;
        rpt_idx_next = rpt_idx;
        rpt_req      = 1'b0;
        if (changed) begin
            rcnt_next  = '0;
            state_next = $onehot(stable_next) ? RPT_HOLD : RPT_IDLE;
            if ($onehot(stable_next)) rpt_idx_next = lowest_set(stable_next);
        end else begin
            case (state)
                RPT_IDLE: begin
                    rcnt_next = '0;
                    if ($onehot(keys_stable)) begin
                        state_next   = RPT_HOLD;
                        rpt_idx_next = lowest_set(keys_stable);
                    end
                end
                RPT_HOLD: begin
                    if (rcnt == RC_W'(REPEAT_DELAY - 1)) begin
                        rpt_req    = 1'b1;
                        rcnt_next  = '0;
                        state_next = RPT_REPEAT;
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt == RC_W'(REPEAT_RATE - 1)) begin
                        rpt_req   = 1'b1;
                        rcnt_next = '0;
                    end
                end
                default: begin
                    state_next = RPT_IDLE;
                    rcnt_next  = '0;
                end
            endcase
        end
    end
`else
    assign pend_rpt = 1'b0;
    assign rpt_idx  = '0;
`endif
endmodule

// File: tb/tb_tm1638_key_events.sv
// Self-checking bench for tm1638_key_events: directed scenarios plus random key traffic
// compared every cycle against a history-based reference model.
module tb_tm1638_key_events;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 8;

    logic       clk_5MHz = 1'b0;
    logic       n_rst;
    logic [7:0] keys_raw;
    logic [7:0] keys_stable;
    logic       event_valid;
    logic [4:0] event_data;
    logic       event_ready;
    logic       event_overflow;

    always #100 clk_5MHz = ~clk_5MHz;

    tm1638_key_events #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_RATE     (RRATE)
    ) dut (
        .clk_5MHz       (clk_5MHz),
        .n_rst          (n_rst),
        .keys_raw       (keys_raw),
        .keys_stable    (keys_stable),
        .event_valid    (event_valid),
        .event_data     (event_data),
        .event_ready    (event_ready),
        .event_overflow (event_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a key flips once its last DEB input samples all disagree with it.
    logic [7:0] m_kq, m_stable, m_pp, m_pr;
    logic [7:0] m_hist [DEB];
    logic       m_prpt, m_ovf, m_hold;
    logic [2:0] m_ridx;
    int         m_hold_edge;
    int         cyc = 0;
    logic [4:0] exp_q[$];
    logic [4:0] acc_q[$];
    int         acc_t[$];

    task automatic model_step();
        logic       pop, push, full, was_rpt, all_diff;
        logic [4:0] ev;
        logic [7:0] flip;
        cyc++;
        if (!n_rst) begin
            m_kq = '0; m_stable = '0; m_pp = '0; m_pr = '0;
            m_prpt = 1'b0; m_ovf = 1'b0; m_hold = 1'b0; m_ridx = '0; m_hold_edge = 0;
            for (int k = 0; k < DEB; k++) m_hist[k] = '0;
            exp_q.delete();
            return;
        end
        pop  = (exp_q.size() > 0) && event_ready;
        full = (exp_q.size() == DEPTH);
        push = 1'b0;
        ev   = '0;
        for (int i = 0; i < 8; i++) if (!push && m_pp[i]) begin push = 1'b1; ev = {2'b01, 3'(i)}; m_pp[i] = 1'b0; end
        for (int i = 0; i < 8; i++) if (!push && m_pr[i]) begin push = 1'b1; ev = {2'b00, 3'(i)}; m_pr[i] = 1'b0; end
        was_rpt = m_prpt;
        if (!push && m_prpt) begin push = 1'b1; ev = {2'b11, m_ridx}; m_prpt = 1'b0; end
        if (pop) void'(exp_q.pop_front());
        if (push && full && !pop) m_ovf = 1'b1;
        else begin
            if (push) exp_q.push_back(ev);
            if (pop)  m_ovf = 1'b0;
        end
        for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_kq;
        flip = '0;
        for (int i = 0; i < 8; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
            flip[i] = all_diff;
        end
        for (int i = 0; i < 8; i++) if (flip[i]) begin
            if (!m_stable[i]) m_pp[i] = 1'b1;
            else              m_pr[i] = 1'b1;
        end
        m_stable = m_stable ^ flip;
`ifdef TM1638_KEY_REPEAT_EN
        // Repeats fall RDLY, RDLY+RRATE, ... cycles after the key became the only one held.
        if (flip == '0 && m_hold && (cyc - m_hold_edge) >= RDLY &&
            ((cyc - m_hold_edge - RDLY) % RRATE) == 0 && !was_rpt)
            m_prpt = 1'b1;
`else
        if (was_rpt) m_prpt = 1'b0;
`endif
        if (flip != '0) begin
            m_hold      = $onehot(m_stable);
            m_hold_edge = cyc;
            if (m_hold) for (int i = 0; i < 8; i++) if (m_stable[i]) m_ridx = 3'(i);
        end
        m_kq = keys_raw;
    endtask

    always @(posedge clk_5MHz) model_step();

    // Each cycle: log the transfer about to happen, then compare after the edge settles.
    task automatic step(input int n);
        repeat (n) begin
            if (n_rst && event_valid && event_ready) begin
                acc_q.push_back(event_data);
                acc_t.push_back(cyc);
            end
            @(negedge clk_5MHz);
            check_eq("keys_stable", keys_stable, m_stable);
            check_eq("event_valid", event_valid, exp_q.size() > 0);
            check_eq("event_data", event_data, (exp_q.size() > 0) ? exp_q[0] : 5'd0);
            check_eq("event_overflow", event_overflow, m_ovf);
        end
    endtask

    initial begin
        n_rst = 1'b0; keys_raw = '0; event_ready = 1'b1;
        @(negedge clk_5MHz);
        step(2);
        check_eq("reset_outputs", {keys_stable, event_valid, event_data, event_overflow}, 15'd0);
        n_rst = 1'b1;
        step(2);

        // Press one key: stable exactly 5 cycles after the input edge.
        keys_raw = 8'h01;
        step(4);
        check_eq("t1_not_yet", keys_stable, 8'h00);
        step(1);
        check_eq("t1_stable", keys_stable, 8'h01);
        step(1);
        check_eq("t1_event", {event_valid, event_data}, 6'b1_01000);
        step(4);
        keys_raw = 8'h00;
        step(10);

        // Short glitch on key 2 must not register.
        acc_q.delete();
        keys_raw = 8'h04;
        step(3);
        keys_raw = 8'h00;
        step(10);
        check_eq("t2_stable", keys_stable, 8'h00);
        check_eq("t2_no_events", acc_q.size(), 0);

        // Two keys at once: presses in index order, then releases.
        acc_q.delete();
        keys_raw = 8'h81;
        step(12);
        keys_raw = 8'h00;
        step(12);
        check_eq("t3_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            check_eq("t3_ev0", acc_q[0], 5'b0_1_000);
            check_eq("t3_ev1", acc_q[1], 5'b0_1_111);
            check_eq("t3_ev2", acc_q[2], 5'b0_0_000);
            check_eq("t3_ev3", acc_q[3], 5'b0_0_111);
        end

        // Consumer stalled: six events into four slots.
        event_ready = 1'b0;
        keys_raw = 8'h07;
        step(8);
        keys_raw = 8'h00;
        step(10);
        check_eq("t4_overflow", event_overflow, 1'b1);
        check_eq("t4_held_head", event_data, 5'b0_1_000);
        acc_q.delete();
        event_ready = 1'b1;
        step(1);
        check_eq("t4_ovf_cleared", event_overflow, 1'b0);
        step(6);
        check_eq("t4_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            check_eq("t4_ev0", acc_q[0], 5'b0_1_000);
            check_eq("t4_ev1", acc_q[1], 5'b0_1_001);
            check_eq("t4_ev2", acc_q[2], 5'b0_1_010);
            check_eq("t4_ev3", acc_q[3], 5'b0_0_000);
        end

        // Reset with queued events and a debounce in flight.
        event_ready = 1'b0;
        keys_raw = 8'h30;
        step(8);
        keys_raw = 8'h00;
        step(2);
        n_rst = 1'b0;
        step(1);
        check_eq("t5_reset", {keys_stable, event_valid, event_data, event_overflow}, 15'd0);
        n_rst = 1'b1;
        acc_q.delete();
        event_ready = 1'b1;
        step(10);
        check_eq("t5_no_stale", acc_q.size(), 0);

`ifdef TM1638_KEY_REPEAT_EN
        acc_q.delete(); acc_t.delete();
        keys_raw = 8'h20;
        step(60);
        keys_raw = 8'h60;
        step(10);
        check_eq("t6_count", acc_q.size(), 7);
        if (acc_q.size() == 7) begin
            check_eq("t6_press", acc_q[0], 5'b0_1_101);
            check_eq("t6_rpt1", acc_q[1], 5'b1_1_101);
            check_eq("t6_gap1", acc_t[1] - acc_t[0], 20);
            check_eq("t6_gap2", acc_t[2] - acc_t[1], 8);
            check_eq("t6_gap3", acc_t[3] - acc_t[2], 8);
            check_eq("t6_key6", acc_q[6], 5'b0_1_110);
        end
        acc_q.delete();
        step(30);
        check_eq("t6_stopped", acc_q.size(), 0);
        keys_raw = 8'h00;
        step(10);
`endif

        // Random traffic against the model.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0:       keys_raw = 8'($urandom_range(0, 255));
                1:       keys_raw = '0;
                default: keys_raw = keys_raw ^ (8'h01 << $urandom_range(0, 7));
            endcase
            event_ready = ($urandom_range(0, 3) != 0);
            n_rst = ($urandom_range(0, 59) != 0);
            step($urandom_range(1, 9));
            n_rst = 1'b1;
        end
        event_ready = 1'b1;
        keys_raw = '0;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
